// File: rtl/uart2sys_pkg.sv
// Shared state encoding, error codes and defaults for the UART program loader.
package uart2sys_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        FLUSH
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_OVR  = 2'b10;
    localparam logic [1:0] ERR_CSUM = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart2sys_frame_timer.sv
// Inter-byte idle counter: cleared by each byte, counts while enabled, saturates at TIMEOUT_CYC-1.
// expire is combinational in the cycle the limit is reached with no byte arriving.
module uart2sys_frame_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            idle_cnt <= '0;
        end else if (clr) begin
            idle_cnt <= '0;
        end else if (en && idle_cnt != LAST) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    // A byte landing on the limit cycle wins over the timeout.
    assign expire = en && !clr && (idle_cnt == LAST);

endmodule

// File: rtl/uart2sys_loader.sv
// Parses SYNC/addr/LEN/data/CSUM frames into 128-bit IRAM words; word valid the cycle after its
// last byte. One-entry output buffer held under !sys_rdy; a word completing into a full buffer aborts.
module uart2sys_loader
    import uart2sys_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              rx_vld,
    input  logic [7:0]        rx_data,
    input  logic              sys_rdy,
    output logic              uart2sys_en,
    output logic [ADDR_W-1:0] uart2sys_addr,
    output logic [127:0]      uart2sys_data,
    output logic              load_done,
    output logic [1:0]        load_err,
    output logic              busy
);
    state_t            state;
    logic [3:0]        byte_cnt;
    logic [8:0]        word_cnt;
    logic [8:0]        word_len;
    logic [11:0]       addr_lo;
    logic [ADDR_W-1:0] cur_addr;
    logic [119:0]      asm_word;
    logic [7:0]        csum;
    logic              tmo_run;
    logic              tmo_expire;

    assign tmo_run = (state == HDR) || (state == DATA) || (state == CSUM);

    uart2sys_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (rx_vld),
        .en     (tmo_run),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            word_len      <= '0;
            addr_lo       <= '0;
            cur_addr      <= '0;
            asm_word      <= '0;
            csum          <= '0;
            uart2sys_en   <= 1'b0;
            uart2sys_addr <= '0;
            uart2sys_data <= '0;
            load_done     <= 1'b0;
            load_err      <= ERR_NONE;
        end else begin
            load_done <= 1'b0;
            if (uart2sys_en && sys_rdy) begin
                uart2sys_en <= 1'b0;
            end

            if (tmo_expire) begin
                load_err <= ERR_TMO;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_vld && rx_data == SYNC_BYTE) begin
                            load_err <= ERR_NONE;
                            byte_cnt <= '0;
                            state    <= HDR;
                        end
                    end
                    HDR: begin
                        if (rx_vld) begin
                            byte_cnt <= byte_cnt + 4'd1;
                            case (byte_cnt[1:0])
                                2'd0: addr_lo[3:0]  <= rx_data[7:4];
                                2'd1: addr_lo[11:4] <= rx_data;
                                2'd2: cur_addr      <= ADDR_W'({rx_data, addr_lo});
                                default: begin
                                    word_len <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                                    csum     <= '0;
                                    word_cnt <= '0;
                                    byte_cnt <= '0;
                                    state    <= DATA;
                                end
                            endcase
                        end
                    end
                    DATA: begin
                        if (rx_vld) begin
                            csum     <= csum ^ rx_data;
                            byte_cnt <= byte_cnt + 4'd1;
                            if (byte_cnt != 4'd15) begin
                                for (int k = 0; k < 15; k++) begin
                                    if (byte_cnt == 4'(k)) asm_word[8*k +: 8] <= rx_data;
                                end
                            end else if (uart2sys_en && !sys_rdy) begin
                                // Buffer still occupied: drop the new word, keep the pending one.
                                load_err <= ERR_OVR;
                                state    <= IDLE;
                            end else begin
                                uart2sys_en   <= 1'b1;
                                uart2sys_addr <= cur_addr;
                                uart2sys_data <= {rx_data, asm_word};
                                cur_addr      <= cur_addr + ADDR_W'(1);
                                word_cnt      <= word_cnt + 9'd1;
                                if (word_cnt + 9'd1 == word_len) state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (rx_vld) begin
                            if (rx_data == csum) begin
                                state <= FLUSH;
                            end else begin
                                load_err <= ERR_CSUM;
                                state    <= IDLE;
                            end
                        end
                    end
                    FLUSH: begin
                        if (!uart2sys_en || sys_rdy) begin
                            load_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE) || uart2sys_en;

endmodule

// File: tb/tb_uart2sys_loader.sv
// Randomized frame stimulus checked against a frame-level reference model plus directed cases.
module tb_uart2sys_loader;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         rx_vld;
    logic [7:0]   rx_data;
    logic         sys_rdy;
    logic         uart2sys_en;
    logic [19:0]  uart2sys_addr;
    logic [127:0] uart2sys_data;
    logic         load_done;
    logic [1:0]   load_err;
    logic         busy;

    always #5 clk = ~clk;

    uart2sys_loader #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .rx_vld        (rx_vld),
        .rx_data       (rx_data),
        .sys_rdy       (sys_rdy),
        .uart2sys_en   (uart2sys_en),
        .uart2sys_addr (uart2sys_addr),
        .uart2sys_data (uart2sys_data),
        .load_done     (load_done),
        .load_err      (load_err),
        .busy          (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: position within the frame, pending output word, expected writes.
    bit           m_active, m_flush, m_pend, m_done;
    int           m_pos, m_len, m_idle, m_base;
    logic [7:0]   m_hdr [4];
    logic [7:0]   m_csum;
    logic [127:0] m_word;
    logic [1:0]   m_err;
    logic [19:0]  exp_addr [$];
    logic [127:0] exp_data [$];

    // Observation records
    logic [19:0]  acc_a [$];
    logic [127:0] acc_d [$];
    int           done_cnt, stall_cnt;
    bit           hold_prev;
    logic [19:0]  hold_a;
    logic [127:0] hold_d;

    int rdy_pct;
    int low_left;

    task automatic model_reset();
        m_active = 0; m_flush = 0; m_pend = 0; m_done = 0;
        m_pos = 0; m_len = 0; m_idle = 0; m_err = 2'b00; m_csum = 8'h00;
        exp_addr.delete(); exp_data.delete();
        hold_prev = 0;
    endtask

    task automatic clr_stats();
        acc_a.delete(); acc_d.delete();
        done_cnt = 0; stall_cnt = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit r);
        bit np, nd;
        int d;
        np = m_pend & !r;
        nd = 0;
        if (!m_active) begin
            if (v && b == 8'hA5) begin
                m_active = 1; m_flush = 0; m_pos = 0; m_err = 2'b00; m_idle = 0;
            end
        end else if (m_flush) begin
            if (!m_pend || r) begin
                m_active = 0; m_flush = 0; nd = 1;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_pos < 4) begin
                m_hdr[m_pos] = b;
                if (m_pos == 3) begin
                    m_len  = (b == 8'd0) ? 256 : int'(b);
                    m_csum = 8'h00;
                    m_base = int'({m_hdr[2], m_hdr[1], m_hdr[0]} >> 4);
                end
                m_pos++;
            end else if (m_pos < 4 + 16 * m_len) begin
                d = m_pos - 4;
                m_word[8*(d%16) +: 8] = b;
                m_csum ^= b;
                if (d % 16 == 15) begin
                    if (m_pend && !r) begin
                        m_err = 2'b10; m_active = 0;
                    end else begin
                        exp_addr.push_back(20'(m_base + d / 16));
                        exp_data.push_back(m_word);
                        np = 1;
                    end
                end
                m_pos++;
            end else if (b == m_csum) begin
                m_flush = 1;
            end else begin
                m_err = 2'b11; m_active = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = 2'b01; m_active = 0;
            end
        end
        m_pend = np;
        m_done = nd;
    endtask

    task automatic sample();
        chk("en", uart2sys_en, m_pend);
        chk("done", load_done, m_done);
        chk("err", load_err, m_err);
        chk("busy", busy, m_active | m_pend);
        if (hold_prev) begin
            chk("hold_addr", uart2sys_addr, hold_a);
            chk("hold_data", uart2sys_data, hold_d);
        end
        hold_prev = uart2sys_en && !sys_rdy;
        hold_a    = uart2sys_addr;
        hold_d    = uart2sys_data;
        if (uart2sys_en && !sys_rdy) stall_cnt++;
        if (load_done) done_cnt++;
        if (uart2sys_en && sys_rdy) begin
            acc_a.push_back(uart2sys_addr);
            acc_d.push_back(uart2sys_data);
            chk("word_expected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) begin
                chk("word_addr", uart2sys_addr, exp_addr.pop_front());
                chk("word_data", uart2sys_data, exp_data.pop_front());
            end
        end
    endtask

    task automatic drive_cycle(input bit v, input logic [7:0] b);
        rx_vld  = v;
        rx_data = v ? b : 8'($urandom);
        if (low_left > 0) begin
            sys_rdy = 1'b0;
            if (uart2sys_en) low_left--;
        end else begin
            sys_rdy = ($urandom_range(99, 0) < rdy_pct);
        end
        @(negedge clk);
        sample();
        model_step(v, b, sys_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) drive_cycle(1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (g) drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b1, b);
    endtask

    // len 1..256; cut_at >= 0 stops after that many data bytes.
    task automatic send_frame(input logic [23:0] a, input int len, input bit seq,
                              input bit bad_cs, input int max_gap, input int cut_at);
        logic [7:0] cs, b;
        cs = 8'h00;
        send_byte(8'hA5, max_gap);
        send_byte(a[7:0], max_gap);
        send_byte(a[15:8], max_gap);
        send_byte(a[23:16], max_gap);
        send_byte(8'(len), max_gap);
        for (int i = 0; i < len * 16; i++) begin
            if (i == cut_at) return;
            b = seq ? i[7:0] : 8'($urandom);
            cs ^= b;
            send_byte(b, max_gap);
        end
        send_byte(bad_cs ? (cs ^ 8'h5A) : cs, max_gap);
    endtask

    initial begin
        rst_b = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; sys_rdy = 1'b0;
        rdy_pct = 100; low_left = 0;
        model_reset();
        clr_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", uart2sys_en, 0);
        chk("rst_addr", uart2sys_addr, 0);
        chk("rst_data", uart2sys_data, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // single word, sequential bytes
        clr_stats();
        send_frame(24'h000020, 1, 1, 0, 0, -1);
        settle(4);
        chk("t1_words", acc_a.size(), 1);
        chk("t1_addr", acc_a[0], 20'h00002);
        chk("t1_data", acc_d[0], 128'h0F0E0D0C0B0A09080706050403020100);
        chk("t1_done", done_cnt, 1);
        chk("t1_err", load_err, 2'b00);

        // five-cycle stall on word 0
        clr_stats();
        low_left = 5;
        send_frame(24'h000020, 2, 1, 0, 0, -1);
        settle(6);
        chk("t2_words", acc_a.size(), 2);
        chk("t2_stall", stall_cnt, 5);
        chk("t2_addr0", acc_a[0], 20'h00002);
        chk("t2_addr1", acc_a[1], 20'h00003);
        chk("t2_data1", acc_d[1], 128'h1F1E1D1C1B1A19181716151413121110);
        chk("t2_done", done_cnt, 1);

        // overrun with sink blocked
        clr_stats();
        rdy_pct = 0;
        send_frame(24'h000020, 2, 1, 0, 0, -1);
        settle(3);
        chk("t3_err", load_err, 2'b10);
        chk("t3_en", uart2sys_en, 1);
        chk("t3_addr", uart2sys_addr, 20'h00002);
        chk("t3_data", uart2sys_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("t3_done", done_cnt, 0);
        rdy_pct = 100;
        settle(3);
        chk("t3_words", acc_a.size(), 1);

        // bad checksum, then SYNC clears the error
        clr_stats();
        send_frame(24'h000020, 1, 1, 1, 0, -1);
        settle(4);
        chk("t4_words", acc_a.size(), 1);
        chk("t4_addr", acc_a[0], 20'h00002);
        chk("t4_err", load_err, 2'b11);
        chk("t4_done", done_cnt, 0);
        drive_cycle(1'b1, 8'hA5);
        chk("t4_clear", load_err, 2'b00);
        settle(20);
        chk("t4_hdr_tmo", load_err, 2'b01);

        // timeout after 3 data bytes, exactly TMO idle cycles
        clr_stats();
        send_frame(24'h000020, 1, 1, 0, 0, 3);
        settle(TMO - 1);
        chk("t5_pre", load_err, 2'b00);
        settle(1);
        chk("t5_err", load_err, 2'b01);
        chk("t5_words", acc_a.size(), 0);
        chk("t5_busy", busy, 0);
        clr_stats();
        send_frame(24'h000020, 1, 1, 0, 0, -1);
        settle(4);
        chk("t5_recover", done_cnt, 1);
        chk("t5_rec_err", load_err, 2'b00);

        // address wrap
        clr_stats();
        send_frame(24'hFFFFF0, 2, 0, 0, 2, -1);
        settle(4);
        chk("t6_addr0", acc_a[0], 20'hFFFFF);
        chk("t6_addr1", acc_a[1], 20'h00000);
        chk("t6_done", done_cnt, 1);

        // async reset mid-DATA with a pending word
        rdy_pct = 0;
        send_frame(24'h000040, 2, 0, 0, 0, 20);
        chk("t6_pend", uart2sys_en, 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("t6_rst_en", uart2sys_en, 0);
        chk("t6_rst_addr", uart2sys_addr, 0);
        chk("t6_rst_data", uart2sys_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", load_err, 0);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rdy_pct = 100;

        // LEN byte 0 means 256 words
        clr_stats();
        send_frame(24'h000100, 256, 0, 0, 0, -1);
        settle(4);
        chk("len0_words", acc_a.size(), 256);
        chk("len0_last", acc_a[255], 20'h0010F);
        chk("len0_done", done_cnt, 1);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            int len, cut, sel;
            sel = $urandom_range(3, 0);
            rdy_pct = (sel == 0) ? 100 : (sel == 1) ? 70 : (sel == 2) ? 30 : 0;
            len = $urandom_range(3, 1);
            cut = ($urandom_range(7, 0) == 0) ? $urandom_range(len * 16 - 1, 0) : -1;
            send_frame(24'($urandom), len, 0, $urandom_range(5, 0) == 0,
                       $urandom_range(3, 0), cut);
            settle($urandom_range(25, 2));
        end
        rdy_pct = 100;
        settle(40);
        chk("queue_empty", exp_addr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
